id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage word-addressed pipeline; the consumer end of the fetch interface.
- Takes the fetched instruction word and resolves Branch/Jump/Stall plus target fields back to the fetch stage in the same cycle.
- Owns the 32x32 register file and the ID/EX pipeline register that feeds the execute stage.

Parameters:
- XLEN, 32, datapath/register width
- NREGS, 32, register-file depth (index width 5)

Ports:
- Clk  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Inst  in  32  instruction held by fetch stage (0 = nop/bubble)
- WbWriteEn  in  1  write-back enable
- WbDest  in  5  write-back register index
- WbData  in  32  write-back data
- MemWriteEn  in  1  MEM-stage instruction writes a register
- MemIsLoad  in  1  MEM-stage instruction is lw (data not yet available)
- MemDest  in  5  MEM-stage destination
- MemData  in  32  MEM-stage ALU result (branch forwarding)
- Branch  out  1  taken branch (combinational)
- Jump  out  1  jump (combinational)
- Stall  out  1  hold fetch PC and Inst (combinational)
- BranchOffset  out  32  sign-extended Inst[15:0], word offset
- JumpAddress  out  26  Inst[25:0], word address
- ExRegA, ExRegB  out  32 each  registered operands
- ExImm  out  32  registered sign-extended immediate
- ExDest  out  5  registered destination index
- ExAluOp  out  3  registered ALU op
- ExAluSrcImm, ExMemRead, ExMemWrite, ExRegWrite  out  1 each  registered controls

Behaviour:
- Decoded set: R-type op 0x00 (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02.
- Anything else, including Inst=0, decodes as a bubble: no controls, no exception.
- Fields: rs=Inst[25:21], rt=Inst[20:16], rd=Inst[15:11]. Dest is rd for R-type and rt for addi/lw. ExRegWrite is forced 0 when dest=0.
- Register file:
  - Write on rising edge when WbWriteEn && WbDest!=0.
  - Reads of $0 return 0.
  - Same-cycle read of WbDest!=0 returns WbData (write-through bypass).
  - Reset clears all registers.
- Branch compare operands: MEM forward (MemWriteEn && !MemIsLoad && MemDest==src && src!=0 -> MemData), else register-file read.
- Stall=1 when any of:
  - (a) load-use: ExMemRead && ExDest!=0 && ExDest matches a source actually read by Inst (rs for all except j; rt for R-type/sw/beq/bne).
  - (b) Inst is beq/bne && ExRegWrite && ExDest in {rs,rt}.
  - (c) Inst is beq/bne && MemWriteEn && MemIsLoad && MemDest!=0 && MemDest in {rs,rt}.
- Branch = !Stall && ((beq && A==B) || (bne && A!=B)).
- Jump = !Stall && op==0x02.
- BranchOffset and JumpAddress are driven from Inst unconditionally, valid only when Branch/Jump=1. Fetch squashes the fetched word itself.
- ID/EX register, updated every rising edge:
  - Reset -> all Ex* = 0.
  - Stall -> load a bubble (all Ex* controls 0).
  - Otherwise -> load the decoded values.
  - beq/bne/j enter ID/EX as bubbles.
- Latency: one cycle from Inst to Ex* outputs. Branch/Jump/Stall resolve in the same cycle, so the fetch stage acts on them at the next edge.
- Simultaneous events: a WB write to a register read by a stalled branch is picked up via the bypass on the retry cycle.
- Reset mid-stall: Reset wins; the ID/EX register and register file clear, and Stall drops once the fetch stage presents Inst=0.

Decomposition:
- Package cpu_defs holds:
  - opcode and funct constants;
  - ALU op encodings ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4;
  - register index width.
- One sub-module, register_file: 2 read ports, 1 write port, $0 hardwired, write-through bypass, synchronous reset.
- Decode, hazard detection and the ID/EX register stay in id_stage.

Test Plan:
- Reset, then Inst=0 -> Branch=Jump=Stall=0; all Ex* = 0 after the next edge.
- WB $1=5 and $2=7; Inst=add $3,$1,$2 (0x00221820) -> next edge ExRegA=5, ExRegB=7, ExDest=3, ExAluOp=ALU_ADD, ExRegWrite=1.
- lw $4,0($1) followed by Inst=add $5,$4,$4 -> Stall=1 for exactly one cycle and ID/EX loads a bubble; the following cycle Stall=0 and the add issues.
- $1=$2=9, Inst=beq $1,$2,-3 (0x1022FFFD) with no hazards -> Branch=1, BranchOffset=0xFFFFFFFD, ExRegWrite=0 after the edge.
- Inst=j 0x0000040 (0x08000040) -> Jump=1, JumpAddress=0x0000040. Same word with an ExMemRead hazard does not exist (j reads no source), so Stall=0.
- bne $6,$0,+2 with MemWriteEn=1, MemIsLoad=0, MemDest=6, MemData=1 and regfile $6=0 -> forwarded compare gives Branch=1. Same case with MemIsLoad=1 -> Stall=1, Branch=0.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared decode constants for the word-addressed 5-stage pipeline.
// Holds opcodes, R-type functs, ALU op encodings and register index width.
package cpu_defs;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int REG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

endpackage

// File: rtl/register_file.sv
// 2-read/1-write register file, $0 hardwired, write-through read bypass.
// Ports: Clk, Reset, ra_a/ra_b -> rd_a/rd_b, we/wa/wd write port.
module register_file
  import cpu_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ra_a,
  input  logic [REG_W-1:0] ra_b,
  output logic [XLEN-1:0]  rd_a,
  output logic [XLEN-1:0]  rd_b,
  input  logic             we,
  input  logic [REG_W-1:0] wa,
  input  logic [XLEN-1:0]  wd
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr;

  assign wr = we && (wa != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (ra_a != '0)
      rd_a = (wr && wa == ra_a) ? wd : regs[ra_a];
    if (ra_b != '0)
      rd_b = (wr && wa == ra_b) ? wd : regs[ra_b];
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decode, branch/jump resolve, hazard stall, ID/EX register.
// Ports: Inst + WB/MEM side inputs; Branch/Jump/Stall to fetch; Ex* to EX.
module id_stage
  import cpu_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [31:0]     Inst,
  input  logic            WbWriteEn,
  input  logic [4:0]      WbDest,
  input  logic [XLEN-1:0] WbData,
  input  logic            MemWriteEn,
  input  logic            MemIsLoad,
  input  logic [4:0]      MemDest,
  input  logic [XLEN-1:0] MemData,
  output logic            Branch,
  output logic            Jump,
  output logic            Stall,
  output logic [31:0]     BranchOffset,
  output logic [25:0]     JumpAddress,
  output logic [XLEN-1:0] ExRegA,
  output logic [XLEN-1:0] ExRegB,
  output logic [XLEN-1:0] ExImm,
  output logic [4:0]      ExDest,
  output logic [2:0]      ExAluOp,
  output logic            ExAluSrcImm,
  output logic            ExMemRead,
  output logic            ExMemWrite,
  output logic            ExRegWrite
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  logic [XLEN-1:0] rd_a, rd_b, imm;
  logic [XLEN-1:0] cmp_a, cmp_b;
  logic is_r, is_addi, is_lw, is_sw;
  logic is_beq, is_bne, is_j, is_br;
  logic use_rs, use_rt, issue;
  logic hz_load, hz_ex, hz_mem;
  logic [4:0] dest;
  alu_op_e alu_op;
  logic src_imm;

  assign op    = Inst[31:26];
  assign funct = Inst[5:0];
  assign rs    = Inst[25:21];
  assign rt    = Inst[20:16];
  assign rd    = Inst[15:11];
  assign imm   = {{(XLEN-16){Inst[15]}}, Inst[15:0]};

  assign is_r = (op == OP_RTYPE) &&
    (funct == FN_ADD || funct == FN_SUB ||
     funct == FN_AND || funct == FN_OR ||
     funct == FN_SLT);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_br   = is_beq || is_bne;

  assign use_rs = is_r || is_addi || is_lw ||
                  is_sw || is_br;
  assign use_rt = is_r || is_sw || is_br;
  assign issue  = is_r || is_addi ||
                  is_lw || is_sw;

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .Clk   (Clk),
    .Reset (Reset),
    .ra_a  (rs),
    .ra_b  (rt),
    .rd_a  (rd_a),
    .rd_b  (rd_b),
    .we    (WbWriteEn),
    .wa    (WbDest),
    .wd    (WbData)
  );

  // ALU results in MEM can feed the compare; loads there cannot.
  always_comb begin
    cmp_a = rd_a;
    cmp_b = rd_b;
    if (MemWriteEn && !MemIsLoad &&
        MemDest == rs && rs != '0)
      cmp_a = MemData;
    if (MemWriteEn && !MemIsLoad &&
        MemDest == rt && rt != '0)
      cmp_b = MemData;
  end

  assign hz_load = ExMemRead && ExDest != '0 &&
    ((use_rs && ExDest == rs) ||
     (use_rt && ExDest == rt));
  assign hz_ex = is_br && ExRegWrite &&
    (ExDest == rs || ExDest == rt);
  assign hz_mem = is_br && MemWriteEn &&
    MemIsLoad && MemDest != '0 &&
    (MemDest == rs || MemDest == rt);

  assign Stall  = hz_load || hz_ex || hz_mem;
  assign Branch = !Stall &&
    ((is_beq && cmp_a == cmp_b) ||
     (is_bne && cmp_a != cmp_b));
  assign Jump   = !Stall && is_j;

  assign BranchOffset = {{16{Inst[15]}}, Inst[15:0]};
  assign JumpAddress  = Inst[25:0];

  always_comb begin
    dest    = '0;
    alu_op  = ALU_ADD;
    src_imm = 1'b0;
    unique case (1'b1)
      is_r: begin
        dest = rd;
        unique case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      is_addi, is_lw: begin
        dest    = rt;
        src_imm = 1'b1;
      end
      is_sw: src_imm = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || Stall || !issue) begin
      ExRegA      <= '0;
      ExRegB      <= '0;
      ExImm       <= '0;
      ExDest      <= '0;
      ExAluOp     <= '0;
      ExAluSrcImm <= 1'b0;
      ExMemRead   <= 1'b0;
      ExMemWrite  <= 1'b0;
      ExRegWrite  <= 1'b0;
    end else begin
      ExRegA      <= rd_a;
      ExRegB      <= rd_b;
      ExImm       <= imm;
      ExDest      <= dest;
      ExAluOp     <= alu_op;
      ExAluSrcImm <= src_imm;
      ExMemRead   <= is_lw;
      ExMemWrite  <= is_sw;
      ExRegWrite  <= (is_r || is_addi || is_lw) &&
                     dest != '0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID/EX bundles queued at drive
// time and compared after the edge; fetch-side outputs checked directly.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [2:0]  op;
    logic        src_imm;
    logic        mr;
    logic        mw;
    logic        rw;
  } ex_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Inst;
  logic        WbWriteEn;
  logic [4:0]  WbDest;
  logic [31:0] WbData;
  logic        MemWriteEn, MemIsLoad;
  logic [4:0]  MemDest;
  logic [31:0] MemData;
  logic        Branch, Jump, Stall;
  logic [31:0] BranchOffset;
  logic [25:0] JumpAddress;
  logic [31:0] ExRegA, ExRegB, ExImm;
  logic [4:0]  ExDest;
  logic [2:0]  ExAluOp;
  logic        ExAluSrcImm, ExMemRead;
  logic        ExMemWrite, ExRegWrite;

  int   n_checks = 0;
  int   n_errors = 0;
  ex_t  exp_q[$];
  ex_t  bub;

  always #5 Clk = ~Clk;

  id_stage dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Inst         (Inst),
    .WbWriteEn    (WbWriteEn),
    .WbDest       (WbDest),
    .WbData       (WbData),
    .MemWriteEn   (MemWriteEn),
    .MemIsLoad    (MemIsLoad),
    .MemDest      (MemDest),
    .MemData      (MemData),
    .Branch       (Branch),
    .Jump         (Jump),
    .Stall        (Stall),
    .BranchOffset (BranchOffset),
    .JumpAddress  (JumpAddress),
    .ExRegA       (ExRegA),
    .ExRegB       (ExRegB),
    .ExImm        (ExImm),
    .ExDest       (ExDest),
    .ExAluOp      (ExAluOp),
    .ExAluSrcImm  (ExAluSrcImm),
    .ExMemRead    (ExMemRead),
    .ExMemWrite   (ExMemWrite),
    .ExRegWrite   (ExRegWrite)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, obs, exp);
    end
  endtask

  function automatic ex_t mk(
    input logic [31:0] a, b, imm,
    input logic [4:0] dest,
    input logic [2:0] op,
    input logic si, mr, mw, rw);
    ex_t e;
    e.a = a; e.b = b; e.imm = imm;
    e.dest = dest; e.op = op;
    e.src_imm = si; e.mr = mr;
    e.mw = mw; e.rw = rw;
    return e;
  endfunction

  // Queue the bundle the current Inst must produce, clock, compare.
  task automatic step(input string tag, input ex_t e);
    ex_t g;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 0, 1);
    end else begin
      g = exp_q.pop_front();
      check({tag, ".a"},    ExRegA, g.a);
      check({tag, ".b"},    ExRegB, g.b);
      check({tag, ".imm"},  ExImm, g.imm);
      check({tag, ".dest"}, {27'd0, ExDest}, {27'd0, g.dest});
      check({tag, ".op"},   {29'd0, ExAluOp}, {29'd0, g.op});
      check({tag, ".ctl"},
            {28'd0, ExAluSrcImm, ExMemRead,
             ExMemWrite, ExRegWrite},
            {28'd0, g.src_imm, g.mr, g.mw, g.rw});
    end
  endtask

  task automatic fetch_chk(input string tag,
                           input logic br,
                           input logic jp,
                           input logic st);
    #1;
    check({tag, ".branch"}, {31'd0, Branch}, {31'd0, br});
    check({tag, ".jump"},   {31'd0, Jump},   {31'd0, jp});
    check({tag, ".stall"},  {31'd0, Stall},  {31'd0, st});
  endtask

  initial begin
    bub = '0;
    Reset = 1'b1; Inst = '0;
    WbWriteEn = 0; WbDest = 0; WbData = 0;
    MemWriteEn = 0; MemIsLoad = 0;
    MemDest = 0; MemData = 0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    fetch_chk("reset", 0, 0, 0);
    step("reset_bub", bub);

    // $1=5, $2=7 via write-back
    WbWriteEn = 1; WbDest = 1; WbData = 5;
    step("wb1", bub);
    WbDest = 2; WbData = 7;
    step("wb2", bub);
    WbWriteEn = 0;

    // add $3,$1,$2
    Inst = 32'h00221820;
    fetch_chk("add", 0, 0, 0);
    step("add", mk(5, 7, 32'h1820, 3, 0, 0, 0, 0, 1));

    // lw $4,0($1)
    Inst = 32'h8C240000;
    fetch_chk("lw", 0, 0, 0);
    step("lw", mk(5, 0, 0, 4, 0, 1, 1, 0, 1));

    // add $5,$4,$4: one load-use stall, then issue
    Inst = 32'h00842820;
    fetch_chk("luse", 0, 0, 1);
    step("luse_bub", bub);
    // load data arrives via WB this cycle: bypass supplies it
    WbWriteEn = 1; WbDest = 4; WbData = 3;
    fetch_chk("luse_retry", 0, 0, 0);
    step("luse_add", mk(3, 3, 32'h2820, 5, 0, 0, 0, 0, 1));

    // $1=$2=9
    Inst = '0;
    WbDest = 1; WbData = 9;
    step("wb9a", bub);
    WbDest = 2;
    step("wb9b", bub);
    WbWriteEn = 0;

    // beq $1,$2,-3
    Inst = 32'h1022FFFD;
    fetch_chk("beq", 1, 0, 0);
    check("beq.off", BranchOffset, 32'hFFFFFFFD);
    step("beq_bub", bub);

    // lw $1,0($2) then j: j reads no source, no stall
    Inst = 32'h8C410000;
    step("lw1", mk(9, 9, 0, 1, 0, 1, 1, 0, 1));
    Inst = 32'h08000040;
    fetch_chk("j", 0, 1, 0);
    check("j.addr", {6'd0, JumpAddress}, 32'h40);
    step("j_bub", bub);

    // bne $6,$0,+2 without forwarding: 0 != 0 false
    Inst = 32'h14C00002;
    fetch_chk("bne_nofwd", 0, 0, 0);
    MemWriteEn = 1; MemIsLoad = 0;
    MemDest = 6; MemData = 1;
    fetch_chk("bne_fwd", 1, 0, 0);
    MemIsLoad = 1;
    fetch_chk("bne_ldhz", 0, 0, 1);
    step("bne_bub", bub);
    MemWriteEn = 0; MemIsLoad = 0;
    MemDest = 0; MemData = 0;

    // addi $7,$0,-1 while WB tries to write $0
    Inst = 32'h2007FFFF;
    WbWriteEn = 1; WbDest = 0; WbData = 55;
    step("addi7",
         mk(0, 0, 32'hFFFFFFFF, 7, 0, 1, 0, 0, 1));
    WbWriteEn = 0;

    // addi $0,$1,1: dest 0 never writes
    Inst = 32'h20200001;
    step("addi0", mk(9, 0, 1, 0, 0, 1, 0, 0, 0));

    // sub $8,$2,$1
    Inst = 32'h00414022;
    step("sub", mk(9, 9, 32'h4022, 8, 1, 0, 0, 0, 1));

    // addi $9,$0,1 then beq $9,$0: EX-stage hazard
    Inst = 32'h20090001;
    step("addi9", mk(0, 0, 1, 9, 0, 1, 0, 0, 1));
    Inst = 32'h11200001;
    fetch_chk("beq_exhz", 0, 0, 1);
    step("beq_exhz_bub", bub);

    // unknown opcode decodes as bubble
    Inst = 32'hFC000000;
    fetch_chk("illegal", 0, 0, 0);
    step("illegal_bub", bub);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
